// File: rtl/cam_dvp_pkg.sv
// Shared definitions for the DVP camera-stream generator and its consumers:
// the frame state encoding and the default sensor timing.
package cam_dvp_pkg;

  // One state per region of the frame; the FSM advances once per pclk period
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_LINE,
    ST_HBLANK,
    ST_VFP
  } cam_state_t;

  // Default OV-style timing, also used by the capture-side benches
  localparam int DEF_LINE_BYTES = 320;
  localparam int DEF_LINES      = 240;
  localparam int DEF_VSYNC_LEN  = 3;
  localparam int DEF_VBP        = 17;
  localparam int DEF_HBLANK     = 16;
  localparam int DEF_VFP        = 10;
  localparam int DEF_PCLK_DIV   = 2;

  // Larger of two integers, used to size the shared period counter
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_pclk_gen.sv
// Pixel-clock divider: while enabled, cam_pclk toggles every PCLK_DIV clk_i
// cycles starting low. rise_en/fall_en flag the clk_i cycle whose edge drives
// cam_pclk high/low, so the caller can launch data on the falling side.
module cam_pclk_gen #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic en,
  output logic cam_pclk,
  output logic fall_en,
  output logic rise_en
);

  localparam int DW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);

  logic [DW-1:0] div_cnt_reg;
  logic          pclk_reg;
  logic          tick;

  assign tick     = en && (div_cnt_reg == DIV_LAST);
  assign rise_en  = tick && !pclk_reg;
  assign fall_en  = tick && pclk_reg;
  assign cam_pclk = pclk_reg;

  // Half-period counter; disabled means held low with the phase reset
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      pclk_reg    <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      pclk_reg    <= 1'b0;
    end else if (tick) begin
      div_cnt_reg <= '0;
      pclk_reg    <= ~pclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + DW'(1);
    end
  end

endmodule

// File: rtl/cam_dvp_tx.sv
// DVP camera-stream generator. Emits whole frames (vsync, back porch, lines
// separated by horizontal blanking, front porch) with a deterministic byte
// pattern (x + y + frame_cnt). All sync/data outputs change only on the edge
// that drives cam_pclk low, so they are stable at every pclk rise.
// Optional macro CAM_DVP_TX_EXT_PIX_EN: pixel bytes come from pix_i, with a
// pix_rd strobe on each launched byte, instead of the internal pattern.
module cam_dvp_tx
  import cam_dvp_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int LINES      = DEF_LINES,
  parameter int VSYNC_LEN  = DEF_VSYNC_LEN,
  parameter int VBP        = DEF_VBP,
  parameter int HBLANK     = DEF_HBLANK,
  parameter int VFP        = DEF_VFP,
  parameter int PCLK_DIV   = DEF_PCLK_DIV
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  output logic       busy,
  output logic       frame_done,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic       cam_pclk,
  output logic [7:0] cam_data
`ifdef CAM_DVP_TX_EXT_PIX_EN
  ,
  input  logic [7:0] pix_i,
  output logic       pix_rd
`endif
);

  localparam int CNT_MAX = max2(max2(max2(VSYNC_LEN, VBP), max2(LINE_BYTES, HBLANK)), VFP);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = $clog2(LINES + 1);

  // Last count value of each region; zero-length porches never reach theirs
  localparam logic [CW-1:0] VSYNC_LAST  = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] VBP_LAST    = CW'((VBP > 0) ? VBP - 1 : 0);
  localparam logic [CW-1:0] LINE_LAST   = CW'(LINE_BYTES - 1);
  localparam logic [CW-1:0] HBLANK_LAST = CW'(HBLANK - 1);
  localparam logic [CW-1:0] VFP_LAST    = CW'((VFP > 0) ? VFP - 1 : 0);
  localparam logic [LW-1:0] LAST_LINE   = LW'(LINES - 1);

  cam_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [LW-1:0] line_reg, line_next;
  logic [7:0]    frame_cnt_reg, frame_cnt_next;
  logic          end_frame;
  logic          upd;
  logic          fall_en;
  logic          rise_en;
  logic          rise_unused;
  logic [7:0]    pix_src;

  logic          vsync_reg, href_reg, frame_done_reg;
  logic [7:0]    data_reg;

  cam_pclk_gen #(
    .PCLK_DIV (PCLK_DIV)
  ) u_pclk_gen (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .en       (state_reg != ST_IDLE),
    .cam_pclk (cam_pclk),
    .fall_en  (fall_en),
    .rise_en  (rise_en)
  );

  // Rise strobe is only of interest to receivers built on the same divider
  assign rise_unused = rise_en;

  // Output launch point: frame start, or any edge that drives pclk low
  assign upd = ((state_reg == ST_IDLE) && start) || fall_en;

`ifdef CAM_DVP_TX_EXT_PIX_EN
  assign pix_src = pix_i;
  assign pix_rd  = upd && (state_next == ST_LINE);
`else
  assign pix_src = 8'(cnt_next) + 8'(line_next) + frame_cnt_next;
`endif

  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = frame_done_reg;
  assign cam_vsync  = vsync_reg;
  assign cam_href   = href_reg;
  assign cam_data   = data_reg;

  // Frame sequencing: region state, period counter, line and frame counters
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    line_next      = line_reg;
    frame_cnt_next = frame_cnt_reg;
    end_frame      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_VSYNC;
          cnt_next   = '0;
          line_next  = '0;
        end
      end
      ST_VSYNC: begin
        if (fall_en) begin
          if (cnt_reg == VSYNC_LAST) begin
            cnt_next   = '0;
            state_next = (VBP == 0) ? ST_LINE : ST_VBP;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_VBP: begin
        if (fall_en) begin
          if (cnt_reg == VBP_LAST) begin
            cnt_next   = '0;
            state_next = ST_LINE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_LINE: begin
        if (fall_en) begin
          if (cnt_reg == LINE_LAST) begin
            cnt_next = '0;
            if (line_reg != LAST_LINE) begin
              state_next = ST_HBLANK;
            end else if (VFP == 0) begin
              end_frame = 1'b1;
            end else begin
              state_next = ST_VFP;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (fall_en) begin
          if (cnt_reg == HBLANK_LAST) begin
            cnt_next   = '0;
            line_next  = line_reg + LW'(1);
            state_next = ST_LINE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_VFP: begin
        if (fall_en) begin
          if (cnt_reg == VFP_LAST) begin
            end_frame = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // End of frame: count it, then restart straight into vsync or go idle
    if (end_frame) begin
      frame_cnt_next = frame_cnt_reg + 8'd1;
      cnt_next       = '0;
      line_next      = '0;
      state_next     = cont ? ST_VSYNC : ST_IDLE;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      line_reg      <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      line_reg      <= line_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // Registered sensor outputs, launched from the upcoming state
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vsync_reg      <= 1'b0;
      href_reg       <= 1'b0;
      data_reg       <= 8'h00;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= end_frame;
      if (upd) begin
        vsync_reg <= (state_next == ST_VSYNC);
        href_reg  <= (state_next == ST_LINE);
        data_reg  <= (state_next == ST_LINE) ? pix_src : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Directed bench for cam_dvp_tx with a small frame (4 bytes x 2 lines,
// PCLK_DIV=1). Sync/data are checked at every pclk rise against the
// hand-derived frame sequence; frame_done/busy are checked at each frame end.
module tb_cam_dvp_tx;

  localparam int LINE_BYTES = 4;
  localparam int LINES      = 2;
  localparam int VSYNC_LEN  = 3;
  localparam int VBP        = 17;
  localparam int HBLANK     = 2;
  localparam int VFP        = 10;
  localparam int PCLK_DIV   = 1;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont  = 1'b0;
  logic       busy, frame_done, cam_vsync, cam_href, cam_pclk;
  logic [7:0] cam_data;
`ifdef CAM_DVP_TX_EXT_PIX_EN
  logic [7:0] pix_i = 8'h00;
  logic       pix_rd;
`endif

  int   checks = 0;
  int   errors = 0;
  logic pclk_prev = 1'b0;
  logic pclk_now  = 1'b0;

  always #5 clk_i = ~clk_i;

  cam_dvp_tx #(
    .LINE_BYTES (LINE_BYTES),
    .LINES      (LINES),
    .VSYNC_LEN  (VSYNC_LEN),
    .VBP        (VBP),
    .HBLANK     (HBLANK),
    .VFP        (VFP),
    .PCLK_DIV   (PCLK_DIV)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .busy       (busy),
    .frame_done (frame_done),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_pclk   (cam_pclk),
    .cam_data   (cam_data)
`ifdef CAM_DVP_TX_EXT_PIX_EN
    ,
    .pix_i      (pix_i),
    .pix_rd     (pix_rd)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clk_i cycle, sampling on the falling edge; start is a 1-cycle pulse
  task automatic tick();
    pclk_prev = pclk_now;
    @(negedge clk_i);
    start    = 1'b0;
    pclk_now = cam_pclk;
  endtask

  task automatic next_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (!pclk_prev && pclk_now) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Check one pclk rise; at rise number poke, drop cont and fire a stray start
  task automatic rise_check(input string tag, input logic ev, input logic eh,
                            input logic [7:0] ed, input int poke, inout int r);
    bit ok;
    next_rise(ok);
    check({tag, "_rise"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_vsync"}, 32'(cam_vsync), 32'(ev));
      check({tag, "_href"}, 32'(cam_href), 32'(eh));
      check({tag, "_data"}, 32'(cam_data), 32'(ed));
      $display("rise %s vsync=%0b href=%0b data=%02h", tag, cam_vsync, cam_href, cam_data);
    end
    if (r == poke) begin
      cont  = 1'b0;
      start = 1'b1;
    end
    r++;
  endtask

  // Whole frame with pattern offset f, then the frame_done pulse and busy state after it
  task automatic check_frame(input logic [7:0] f, input int poke, input logic exp_busy);
    int         r;
    bit         found;
    logic [7:0] ed;
    r = 0;
    for (int i = 0; i < VSYNC_LEN; i++) rise_check($sformatf("f%0h_vs%0d", f, i), 1'b1, 1'b0, 8'h00, poke, r);
    for (int i = 0; i < VBP; i++) rise_check($sformatf("f%0h_vbp%0d", f, i), 1'b0, 1'b0, 8'h00, poke, r);
    for (int y = 0; y < LINES; y++) begin
      for (int x = 0; x < LINE_BYTES; x++) begin
        ed = f + 8'(x) + 8'(y);
        rise_check($sformatf("f%0h_y%0d_x%0d", f, y, x), 1'b0, 1'b1, ed, poke, r);
      end
      if (y < LINES - 1)
        for (int i = 0; i < HBLANK; i++) rise_check($sformatf("f%0h_hb%0d", f, i), 1'b0, 1'b0, 8'h00, poke, r);
    end
    for (int i = 0; i < VFP; i++) rise_check($sformatf("f%0h_vfp%0d", f, i), 1'b0, 1'b0, 8'h00, poke, r);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      found = (frame_done === 1'b1);
    end
    check($sformatf("f%0h_frame_done", f), 32'(found), 32'd1);
    check($sformatf("f%0h_busy_after", f), 32'(busy), 32'(exp_busy));
    check($sformatf("f%0h_vsync_after", f), 32'(cam_vsync), 32'(exp_busy));
    check($sformatf("f%0h_pclk_after", f), 32'(cam_pclk), 32'd0);
    $display("frame %0h done busy=%0b", f, busy);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_vsync"}, 32'(cam_vsync), 32'd0);
    check({tag, "_href"}, 32'(cam_href), 32'd0);
    check({tag, "_pclk"}, 32'(cam_pclk), 32'd0);
    check({tag, "_data"}, 32'(cam_data), 32'd0);
    $display("idle %s busy=%0b pclk=%0b", tag, busy, cam_pclk);
  endtask

  initial begin
    bit ok;
    int n;
    int cyc;

    // Reset state
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("post_reset");

    // Single frame, cont=0
    start = 1'b1;
    check_frame(8'h00, -1, 1'b0);
    tick();
    check("done_one_cycle", 32'(frame_done), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check_idle("after_single");

    // Continuous frames; in the third, drop cont and fire a start while busy
    cont  = 1'b1;
    start = 1'b1;
    check_frame(8'h01, -1, 1'b1);
    check_frame(8'h02, -1, 1'b1);
    check_frame(8'h03, 10, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) tick();
    check_idle("after_cont");

    // Reset in the middle of a line, then a clean frame from a cleared frame count
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      next_rise(ok);
      ok = ok && (cam_href === 1'b1);
    end
    check("mid_line_reached", 32'(ok), 32'd1);
    #3 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk_i);
    rst_n    = 1'b1;
    pclk_now = cam_pclk;
    tick();
    check_idle("after_async_reset");
    start = 1'b1;
    check_frame(8'h00, -1, 1'b0);

    // Frame counter wrap: frames 1..255 free-run, the next one starts at 00 again
    cont  = 1'b1;
    start = 1'b1;
    n     = 0;
    cyc   = 0;
    while (n < 255 && cyc < 25000) begin
      tick();
      cyc++;
      if (frame_done === 1'b1) n++;
    end
    check("wrap_frames", 32'(n), 32'd255);
    check_frame(8'h00, 5, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    check_idle("after_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
